// File: rtl/servo_pkg.sv
// Shared servo definitions: direction codes, sequencer state encodings and the
// mapping that folds undefined direction codes onto a safe stop.
package servo_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'b000,
        DIR_FWD   = 3'b001,
        DIR_BACK  = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_RIGHT = 3'b100
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_STOP = 2'b11
    } state_e;

    // Codes above DIR_RIGHT are undefined and must never reach the servo.
    function automatic logic [2:0] map_dir(input logic [2:0] code);
        logic [2:0] res;
        if (code > 3'b100) begin
            res = DIR_STOP;
        end else begin
            res = code;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO with synchronous flush; DEPTH must be a power of two.
module cmd_fifo
    import servo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = push && !full_s;
    assign pop_s   = pop && !empty_s;
    assign full    = full_s;
    assign empty   = empty_s;
    assign dout    = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/servo_move_sequencer.sv
// Queues timed movement commands and plays them to the servo controller as
// direction/strobe pairs, each direction held for cmd_ms milliseconds.
module servo_move_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int FIFO_DEPTH = 4,
    parameter int MS_W       = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_dir,
    input  logic [MS_W-1:0] cmd_ms,
    input  logic            abort,
    output logic [2:0]      direction,
    output logic            use_servo,
    output logic            busy,
    output logic            done
);

    localparam int TICKS_PER_MS = CLK_HZ / 1000;
    localparam int TICK_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int ENTRY_W      = 3 + MS_W;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

    state_e              state_r, state_s;
    logic [TICK_W-1:0]   tick_r, tick_s;
    logic [MS_W-1:0]     ms_r, ms_s;
    logic [MS_W-1:0]     cur_ms_r, cur_ms_s;
    logic [2:0]          dir_r, dir_s;
    logic                use_r, use_s;
    logic                done_r, done_s;
    logic                pop_s;
    logic                flush_s;
    logic                push_s;
    logic                full_s;
    logic                empty_s;
    logic                ready_s;
    logic                last_s;
    logic [ENTRY_W-1:0]  head_s;
    logic [2:0]          head_dir_s;
    logic [MS_W-1:0]     head_ms_s;

    assign ready_s    = rst_n && !full_s && !abort;
    assign push_s     = cmd_valid && ready_s;
    assign head_dir_s = head_s[ENTRY_W-1:MS_W];
    assign head_ms_s  = head_s[MS_W-1:0];

    // The strobe cycle counts as the first held cycle, so the hold ends one
    // cycle before ms*TICKS elapses; a zero-length command ends immediately.
    assign last_s = (cur_ms_r == {MS_W{1'b0}}) ||
                    ((({1'b0, ms_r} + (MS_W+1)'(1)) == {1'b0, cur_ms_r}) &&
                     (tick_r == TICK_LAST));

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   ({cmd_dir, cmd_ms}),
        .pop   (pop_s),
        .flush (flush_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state and next-output logic; abort overrides every other event.
    always_comb begin
        state_s  = state_r;
        tick_s   = tick_r;
        ms_s     = ms_r;
        cur_ms_s = cur_ms_r;
        dir_s    = dir_r;
        use_s    = 1'b0;
        done_s   = 1'b0;
        pop_s    = 1'b0;
        flush_s  = 1'b0;
        if (abort) begin
            flush_s = 1'b1;
            if ((state_r != ST_IDLE) || !empty_s) begin
                state_s = ST_STOP;
                dir_s   = DIR_STOP;
                use_s   = 1'b1;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        state_s  = ST_LOAD;
                        dir_s    = map_dir(head_dir_s);
                        use_s    = 1'b1;
                        cur_ms_s = head_ms_s;
                        tick_s   = {TICK_W{1'b0}};
                        ms_s     = {MS_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD, ST_RUN: begin
                    if (last_s && !empty_s) begin
                        pop_s    = 1'b1;
                        state_s  = ST_LOAD;
                        dir_s    = map_dir(head_dir_s);
                        use_s    = 1'b1;
                        cur_ms_s = head_ms_s;
                        tick_s   = {TICK_W{1'b0}};
                        ms_s     = {MS_W{1'b0}};
                    end else if (last_s) begin
                        state_s = ST_STOP;
                        dir_s   = DIR_STOP;
                        use_s   = 1'b1;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        if (tick_r == TICK_LAST) begin
                            tick_s = {TICK_W{1'b0}};
                            ms_s   = ms_r + MS_W'(1);
                        end else begin
                            tick_s = tick_r + TICK_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    dir_s   = DIR_STOP;
                end
            endcase
        end
    end

    // State, counters and registered servo outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            tick_r   <= {TICK_W{1'b0}};
            ms_r     <= {MS_W{1'b0}};
            cur_ms_r <= {MS_W{1'b0}};
            dir_r    <= DIR_STOP;
            use_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            tick_r   <= tick_s;
            ms_r     <= ms_s;
            cur_ms_r <= cur_ms_s;
            dir_r    <= dir_s;
            use_r    <= use_s;
            done_r   <= done_s;
        end
    end

    assign cmd_ready = ready_s;
    assign direction = dir_r;
    assign use_servo = use_r;
    assign done      = done_r;
    assign busy      = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: doc/servo_move_sequencer.md
SERVO_MOVE_SEQUENCER -- requirements
Module: servo_move_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-003 SHALL have parameter MS_W, default 12, width of the duration field in milliseconds.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-008 SHALL have port cmd_dir  input  3  direction code: 000 stop, 001 forward, 010 backward, 011 left, 100 right.
REQ-009 SHALL have port cmd_ms  input  MS_W  hold time in ms.
REQ-010 SHALL have port abort  input  1  flush queue and stop.
REQ-011 SHALL have port direction  output  3  registered direction to servo controller.
REQ-012 SHALL have port use_servo  output  1  one-cycle strobe; servo controller latches direction.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE, or while queue non-empty.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the queue drains naturally.

Function
REQ-015 SHALL derive TICKS_PER_MS = CLK_HZ/1000 (integer division); tick counter width = clog2(TICKS_PER_MS).
REQ-016 SHALL buffer accepted commands {cmd_dir, cmd_ms} in a FIFO_DEPTH-entry FIFO, first-in first-out.
REQ-017 SHALL drive cmd_ready = !full && !abort; no push occurs when full or during abort.
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN, STOP.
REQ-019 IDLE: if FIFO non-empty, pop head and go to LOAD at the next edge; otherwise stay.
REQ-020 LOAD (one cycle): direction = popped cmd_dir (codes 101-111 mapped to 000), use_servo = 1, ms counter and tick counter cleared.
REQ-021 RUN: tick counter wraps at TICKS_PER_MS-1 and increments the ms counter on wrap; direction held.
REQ-022 SHALL hold each direction exactly cmd_ms*TICKS_PER_MS cycles, measured from its use_servo pulse to the next use_servo pulse.
REQ-023 On RUN expiry: if FIFO non-empty, pop and perform LOAD behaviour in the same transition (back-to-back, no gap); else go to STOP.
REQ-024 cmd_ms = 0: command SHALL still emit its use_servo pulse and then hold for exactly one cycle.
REQ-025 STOP (one cycle): direction = 000, use_servo = 1, done = 1; then IDLE.
REQ-026 abort SHALL have priority over all events: FIFO flushed, next cycle in STOP with direction = 000, use_servo = 1, done = 0.
REQ-027 abort in IDLE with empty FIFO SHALL produce no use_servo pulse.
REQ-028 A push and a pop on the same edge SHALL both take effect; occupancy is unchanged.
REQ-029 use_servo and done SHALL be low in every cycle not named above.
REQ-030 ms counter SHALL be MS_W bits; comparison against cmd_ms never wraps.

Reset
REQ-031 While rst_n = 0: state = IDLE, FIFO empty, counters 0, direction = 000, use_servo = 0, done = 0, busy = 0, cmd_ready = 0.
REQ-032 Reset mid-RUN SHALL discard the current and queued commands immediately, with no STOP pulse.
REQ-033 After rst_n rises, cmd_ready SHALL be 1 in the first cycle.

Structure
REQ-034 Direction codes (DIR_STOP..DIR_RIGHT) and FSM state encodings SHALL reside in shared package servo_pkg, which the servo controller also uses.
REQ-035 The FIFO SHALL be one sub-module, cmd_fifo (parameters DEPTH, WIDTH; push/pop/full/empty/flush).

Verification (benches SHALL use CLK_HZ = 10000, so TICKS_PER_MS = 10)
REQ-036 One command {001, 3 ms} from IDLE: use_servo at cycle N, direction = 001 for 30 cycles, then STOP pulse with direction = 000 and done = 1.
REQ-037 Push {001,2}, {011,1}, {100,0} back-to-back: pulses at N, N+20, N+30, then STOP at N+31; directions 001/011/100/000.
REQ-038 Offer 5 commands with FIFO_DEPTH = 4 while RUN holds a long command: cmd_ready drops after the 4th accept and the 5th is accepted only after the next pop.
REQ-039 abort at cycle 15 of a {010, 5 ms} command with 2 queued: next cycle direction = 000, use_servo = 1, done = 0, FIFO empty, busy low after.
REQ-040 rst_n low mid-RUN of {001, 4 ms}: outputs 0 asynchronously, no pulse after release; cmd_dir = 110 with 1 ms gives direction = 000 for 10 cycles.
